light_scheduler: RTL and testbench

//  Sequences the 4-way intersection signal heads from the car-score block output (c_out score, c_dir).

---
 rtl/traffic_pkg.sv | 26 ++
 rtl/phase_timer.sv | 38 +++
 rtl/light_scheduler.sv | 169 ++++++++++++++++
 tb/tb_light_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the intersection signal scheduler.
//   light_t       : lamp colour driven onto a signal head
//   sched_state_t : scheduler phase
//   AXIS_NS/EW    : bit positions of each axis in the pedestrian latch
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } light_t;

  typedef enum logic [2:0] {
    INIT_RED  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    NS_CLEAR  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    EW_CLEAR  = 3'd6
  } sched_state_t;

  localparam int unsigned AXIS_NS = 1;
  localparam int unsigned AXIS_EW = 0;

endpackage

// File: rtl/phase_timer.sv
// Saturating per-phase seconds counter.
//   clk, n_rst : clock, async active-low reset
//   clr_i      : restart the count at zero (wins over tick_i)
//   tick_i     : one-second strobe, advances the count
//   count_o    : seconds spent in the current phase, sticks at all-ones
module phase_timer #(
  parameter int unsigned TMR_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr_i,
  input  logic             tick_i,
  output logic [TMR_W-1:0] count_o
);

  logic [TMR_W-1:0] count_q, count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (tick_i && !(&count_q)) begin
      count_d = count_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/light_scheduler.sv
// Four-way intersection phase sequencer (NS/EW green, yellow, all-red).
//   clk, n_rst : clock, async active-low reset
//   sec_tick   : one-clk strobe per second; all phase timing counts it
//   c_score    : busiest-axis car count (0 = no traffic)
//   c_dir      : busier axis, 1 = NS, 0 = EW
//   p_req      : pedestrian buttons, [1] = NS walk, [0] = EW walk
//   ns_light   : NS head colour (light_t)
//   ew_light   : EW head colour (light_t)
//   walk_ns    : NS walk lamp
//   walk_ew    : EW walk lamp
//   phase_done : one-clk pulse when new lights first appear
module light_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_GREEN = 10,
  parameter int unsigned MAX_GREEN = 60,
  parameter int unsigned YELLOW_T  = 4,
  parameter int unsigned ALL_RED_T = 2,
  parameter int unsigned TMR_W     = 7
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sec_tick,
  input  logic [6:0] c_score,
  input  logic       c_dir,
  input  logic [1:0] p_req,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic       phase_done
);

  sched_state_t     state_q, state_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       pend_clr;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] elapsed;
  logic [TMR_W-1:0] timer_nxt;
  logic             state_chg;
  logic             traffic;
  logic             min_met;
  logic             max_met;
  logic             end_ns_green;
  logic             end_ew_green;
  logic             walk_ok;

  light_t ns_q, ns_d;
  light_t ew_q, ew_d;
  logic   walk_ns_q, walk_ns_d;
  logic   walk_ew_q, walk_ew_d;
  logic   done_q;

  phase_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr_i   (state_chg),
    .tick_i  (sec_tick),
    .count_o (timer_q)
  );

  // Timer value as it will read after this cycle's tick (saturating).
  always_comb begin
    elapsed = timer_q;
    if (!(&timer_q)) begin
      elapsed = timer_q + TMR_W'(1);
    end
  end

  // Green-end conditions; score >100 still counts as traffic.
  always_comb begin
    traffic      = (c_score != 7'd0);
    min_met      = (elapsed >= TMR_W'(MIN_GREEN));
    max_met      = (elapsed >= TMR_W'(MAX_GREEN));
    end_ns_green = min_met && ((traffic && !c_dir) || pend_q[AXIS_EW] || (traffic && max_met));
    end_ew_green = min_met && ((traffic &&  c_dir) || pend_q[AXIS_NS] || (traffic && max_met));
  end

  // Phase sequencing; decisions are taken only in tick cycles.
  always_comb begin
    state_d = state_q;
    if (sec_tick) begin
      case (state_q)
        INIT_RED:  if (elapsed == TMR_W'(ALL_RED_T)) state_d = NS_GREEN;
        NS_GREEN:  if (end_ns_green)                 state_d = NS_YELLOW;
        NS_YELLOW: if (elapsed == TMR_W'(YELLOW_T))  state_d = NS_CLEAR;
        NS_CLEAR:  if (elapsed == TMR_W'(ALL_RED_T)) state_d = EW_GREEN;
        EW_GREEN:  if (end_ew_green)                 state_d = EW_YELLOW;
        EW_YELLOW: if (elapsed == TMR_W'(YELLOW_T))  state_d = EW_CLEAR;
        EW_CLEAR:  if (elapsed == TMR_W'(ALL_RED_T)) state_d = NS_GREEN;
        default:                                     state_d = INIT_RED;
      endcase
    end
  end

  assign state_chg = (state_d != state_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= INIT_RED;
    end else begin
      state_q <= state_d;
    end
  end

  // Pedestrian latch: a press in the entry cycle survives the clear.
  always_comb begin
    pend_clr          = 2'b00;
    pend_clr[AXIS_NS] = state_chg && (state_d == NS_GREEN);
    pend_clr[AXIS_EW] = state_chg && (state_d == EW_GREEN);
    pend_d            = (pend_q & ~pend_clr) | p_req;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pend_q <= 2'b00;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Lamp decode from the upcoming state so lights land with phase_done.
  always_comb begin
    ns_d      = RED;
    ew_d      = RED;
    walk_ns_d = 1'b0;
    walk_ew_d = 1'b0;
    timer_nxt = state_chg ? '0 : (sec_tick ? elapsed : timer_q);
    walk_ok   = (timer_nxt < TMR_W'(MIN_GREEN));
    case (state_d)
      NS_GREEN: begin
        ns_d      = GREEN;
        walk_ns_d = walk_ok;
      end
      NS_YELLOW: ns_d = YELLOW;
      EW_GREEN: begin
        ew_d      = GREEN;
        walk_ew_d = walk_ok;
      end
      EW_YELLOW: ew_d = YELLOW;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ns_q      <= RED;
      ew_q      <= RED;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      ns_q      <= ns_d;
      ew_q      <= ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      done_q    <= state_chg;
    end
  end

  assign ns_light   = ns_q;
  assign ew_light   = ew_q;
  assign walk_ns    = walk_ns_q;
  assign walk_ew    = walk_ew_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_light_scheduler.sv
// Self-checking bench for light_scheduler against a phase-level model.
module tb_light_scheduler;

  localparam int MIN_G = 10;
  localparam int MAX_G = 60;
  localparam int YEL   = 4;
  localparam int AR    = 2;
  localparam int TSAT  = 127;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sec_tick;
  logic [6:0] c_score;
  logic       c_dir;
  logic [1:0] p_req;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       walk_ns;
  logic       walk_ew;
  logic       phase_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  light_scheduler dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sec_tick   (sec_tick),
    .c_score    (c_score),
    .c_dir      (c_dir),
    .p_req      (p_req),
    .ns_light   (ns_light),
    .ew_light   (ew_light),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .phase_done (phase_done)
  );

  // Model: phase 0=init-red 1=green 2=yellow 3=clear; axis 1=NS 0=EW.
  int         m_phase;
  int         m_axis;
  int         m_t;
  logic [1:0] m_pend;
  logic       m_done;

  task automatic model_reset();
    m_phase = 0; m_axis = 1; m_t = 0; m_pend = 2'b00; m_done = 1'b0;
  endtask

  task automatic model_step(input logic tk, input int score, input int dir, input logic [1:0] pr);
    int e;
    int other;
    logic busy;
    logic [1:0] clr;
    m_done = 1'b0;
    clr    = 2'b00;
    if (tk) begin
      e     = (m_t + 1 > TSAT) ? TSAT : m_t + 1;
      other = 1 - m_axis;
      busy  = (score != 0);
      case (m_phase)
        0: if (e == AR) begin m_phase = 1; m_axis = 1; m_done = 1'b1; end
        1: if (e >= MIN_G && ((busy && dir == other) || m_pend[other] || (busy && e >= MAX_G))) begin
             m_phase = 2; m_done = 1'b1;
           end
        2: if (e == YEL) begin m_phase = 3; m_done = 1'b1; end
        3: if (e == AR) begin m_phase = 1; m_axis = other; m_done = 1'b1; end
        default: ;
      endcase
      m_t = m_done ? 0 : e;
      if (m_done && m_phase == 1) clr[m_axis] = 1'b1;
    end
    m_pend = (m_pend & ~clr) | pr;
  endtask

  function automatic logic [6:0] model_out();
    int lamp;
    int ns;
    int ew;
    logic walk;
    lamp = (m_phase == 1) ? 2 : (m_phase == 2) ? 1 : 0;
    ns   = (m_axis == 1) ? lamp : 0;
    ew   = (m_axis == 0) ? lamp : 0;
    walk = (m_phase == 1) && (m_t < MIN_G);
    return {2'(ns), 2'(ew), walk && (m_axis == 1), walk && (m_axis == 0), m_done};
  endfunction

  // One clock with the given tick/press; model advances on the same edge.
  task automatic clk_step(input logic tk, input logic [1:0] pr);
    sec_tick = tk;
    p_req    = pr;
    @(posedge clk);
    model_step(tk, int'(c_score), int'(c_dir), pr);
    #1;
    sec_tick = 1'b0;
    p_req    = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_step(1'b0, 2'b00);
  endtask

  task automatic do_reset();
    n_rst    = 1'b0;
    sec_tick = 1'b0;
    p_req    = 2'b00;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic go_ns_green();
    do_reset();
    c_score = 7'd0;
    clk_step(1'b1, 2'b00);
    idle(1);
    clk_step(1'b1, 2'b00);
    total++;
    if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
      $display("FAIL setup_ns_green got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
    else passed++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; sec_tick = 1'b0; c_score = 7'd0; c_dir = 1'b0; p_req = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== 7'b0)
      $display("FAIL reset_outputs got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, 7'b0);
    else passed++;
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_rest_ns();
    c_score = 7'd0;
    for (int k = 1; k <= 2; k++) begin
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL init_tick k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      idle(1);
    end
    for (int k = 1; k <= 200; k++) begin
      c_dir = 1'($urandom_range(0, 1));
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out() || ew_light !== 2'd0)
        $display("FAIL rest_ns k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      idle($urandom_range(0, 2));
    end
    total++;
    if (ns_light !== 2'd2)
      $display("FAIL rest_ns_final ns_light=%0d exp=2", ns_light);
    else passed++;
  endtask

  task automatic test_score_switch();
    int evt[$];
    go_ns_green();
    c_score = 7'd30; c_dir = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL score_switch k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      if (phase_done) evt.push_back(k);
      idle($urandom_range(0, 2));
    end
    total++;
    if (evt.size() != 3 || evt[0] != 10 || evt[1] != 14 || evt[2] != 16)
      $display("FAIL score_switch_events got=%p exp='{10, 14, 16}", evt);
    else passed++;
    total++;
    if (ew_light !== 2'd2 || ns_light !== 2'd0)
      $display("FAIL score_switch_ew_green ns=%0d ew=%0d exp ns=0 ew=2", ns_light, ew_light);
    else passed++;
  endtask

  task automatic test_max_green();
    int yel_at = -1;
    go_ns_green();
    c_score = 7'd50; c_dir = 1'b1;
    for (int k = 1; k <= 70 && yel_at < 0; k++) begin
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL max_green k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      if (ns_light == 2'd1) yel_at = k;
      idle($urandom_range(0, 2));
    end
    total++;
    if (yel_at != MAX_G) $display("FAIL max_green_tick got=%0d exp=%0d", yel_at, MAX_G);
    else passed++;
  endtask

  task automatic test_ped_walk();
    int yel_at = -1;
    int walks  = 0;
    go_ns_green();
    c_score = 7'd30; c_dir = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_step(1'b1, 2'b00);
      idle(1);
    end
    c_score = 7'd0;
    for (int k = 1; k <= 30 && yel_at < 0; k++) begin
      if (k == 4) begin
        clk_step(1'b0, 2'b10);
        total++;
        if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
          $display("FAIL ped_press got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
        else passed++;
      end
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL ped_ew k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      if (ew_light == 2'd1) yel_at = k;
      idle(1);
    end
    total++;
    if (yel_at != MIN_G) $display("FAIL ped_ew_yellow_tick got=%0d exp=%0d", yel_at, MIN_G);
    else passed++;
    for (int k = 1; k <= 6; k++) begin
      clk_step(1'b1, 2'b00);
      idle(1);
    end
    total++;
    if (ns_light !== 2'd2 || walk_ns !== 1'b1)
      $display("FAIL ped_ns_entry ns=%0d walk_ns=%b exp ns=2 walk_ns=1", ns_light, walk_ns);
    else passed++;
    for (int k = 1; k <= 12; k++) begin
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL ped_walk k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      if (walk_ns) walks++;
      idle($urandom_range(0, 2));
    end
    total++;
    if (walks != MIN_G - 1) $display("FAIL ped_walk_ticks got=%0d exp=%0d", walks, MIN_G - 1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    go_ns_green();
    c_score = 7'd30; c_dir = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      clk_step(1'b1, 2'b00);
      idle(1);
    end
    total++;
    if (ns_light !== 2'd1) $display("FAIL reset_mid_pre ns=%0d exp=1", ns_light);
    else passed++;
    #1;
    n_rst = 1'b0;
    #1;
    total++;
    if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== 7'b0)
      $display("FAIL reset_mid_async got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, 7'b0);
    else passed++;
    model_reset();
    @(posedge clk);
    #1;
    n_rst   = 1'b1;
    c_score = 7'd0;
    clk_step(1'b1, 2'b00);
    total++;
    if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
      $display("FAIL reset_mid_tick1 got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
    else passed++;
    idle(1);
    clk_step(1'b1, 2'b00);
    total++;
    if (ns_light !== 2'd2 || ew_light !== 2'd0 || phase_done !== 1'b1)
      $display("FAIL reset_mid_reenter ns=%0d ew=%0d done=%b exp ns=2 ew=0 done=1", ns_light, ew_light, phase_done);
    else passed++;
  endtask

  task automatic test_ped_entry();
    int yel_at = -1;
    do_reset();
    c_score = 7'd0;
    clk_step(1'b1, 2'b00);
    idle(1);
    clk_step(1'b1, 2'b10);
    total++;
    if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
      $display("FAIL ped_entry got=%b exp=%b", {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
    else passed++;
    c_score = 7'd30; c_dir = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      clk_step(1'b1, 2'b00);
      idle(1);
    end
    c_score = 7'd0;
    for (int k = 1; k <= 30 && yel_at < 0; k++) begin
      clk_step(1'b1, 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL ped_entry_ew k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      if (ew_light == 2'd1) yel_at = k;
      idle($urandom_range(0, 1));
    end
    total++;
    if (yel_at != MIN_G) $display("FAIL ped_entry_ew_end got=%0d exp=%0d", yel_at, MIN_G);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 700; k++) begin
      c_score = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      c_dir   = 1'($urandom_range(0, 1));
      clk_step(1'b1, ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      total++;
      if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
        $display("FAIL random_tick k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
      else passed++;
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
        clk_step(1'b0, ($urandom_range(0, 29) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        total++;
        if ({ns_light, ew_light, walk_ns, walk_ew, phase_done} !== model_out())
          $display("FAIL random_idle k=%0d got=%b exp=%b", k, {ns_light, ew_light, walk_ns, walk_ew, phase_done}, model_out());
        else passed++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rest_ns();
    test_score_switch();
    test_max_green();
    test_ped_walk();
    test_reset_mid();
    test_ped_entry();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
